// File: rtl/filter_channel_scheduler.sv
// Stereo frame scheduler: time-multiplexes one shared filter engine across the L and R
// channels, with bypass, per-channel wait timeout and sticky overrun/timeout flags.
module filter_channel_scheduler #(
    parameter int unsigned W       = 24,
    parameter int unsigned TIMEOUT = 1000
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         smp_ready,
    input  logic [W-1:0] l_in,
    input  logic [W-1:0] r_in,
    input  logic         bypass,
    input  logic         clr_flags,
    output logic         flt_start,
    output logic [W-1:0] flt_din,
    output logic         flt_chan,
    input  logic         flt_done,
    input  logic [W-1:0] flt_dout,
    output logic [W-1:0] l_out,
    output logic [W-1:0] r_out,
    output logic         out_valid,
    output logic         busy,
    output logic         overrun,
    output logic         timeout_err
);

    localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CntLast = CW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        StIdle,
        StStartL,
        StWaitL,
        StStartR,
        StWaitR
    } state_t;

    state_t        state_q, state_d;
    logic [W-1:0]  l_lat_q, l_lat_d;
    logic [W-1:0]  r_lat_q, r_lat_d;
    logic [W-1:0]  l_res_q, l_res_d;
    logic [W-1:0]  flt_din_q, flt_din_d;
    logic          flt_chan_q, flt_chan_d;
    logic [W-1:0]  l_out_q, l_out_d;
    logic [W-1:0]  r_out_q, r_out_d;
    logic          out_valid_q, out_valid_d;
    logic          overrun_q, overrun_d;
    logic          timeout_err_q, timeout_err_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          wait_expired;
    logic          timeout_set;
    logic          overrun_set;

    assign wait_expired = (cnt_q == CntLast);

    always_comb begin
        state_d     = state_q;
        l_lat_d     = l_lat_q;
        r_lat_d     = r_lat_q;
        l_res_d     = l_res_q;
        flt_din_d   = flt_din_q;
        flt_chan_d  = flt_chan_q;
        l_out_d     = l_out_q;
        r_out_d     = r_out_q;
        out_valid_d = 1'b0;
        cnt_d       = cnt_q;
        timeout_set = 1'b0;
        overrun_set = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (smp_ready) begin
                    if (bypass) begin
                        l_out_d     = l_in;
                        r_out_d     = r_in;
                        out_valid_d = 1'b1;
                    end else begin
                        l_lat_d    = l_in;
                        r_lat_d    = r_in;
                        flt_din_d  = l_in;
                        flt_chan_d = 1'b0;
                        state_d    = StStartL;
                    end
                end
            end
            StStartL: begin
                cnt_d   = '0;
                state_d = StWaitL;
            end
            StWaitL: begin
                // A done on the expiry cycle takes priority over the timeout.
                if (flt_done || wait_expired) begin
                    l_res_d     = flt_done ? flt_dout : l_lat_q;
                    timeout_set = ~flt_done;
                    flt_din_d   = r_lat_q;
                    flt_chan_d  = 1'b1;
                    state_d     = StStartR;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            StStartR: begin
                cnt_d   = '0;
                state_d = StWaitR;
            end
            StWaitR: begin
                if (flt_done || wait_expired) begin
                    l_out_d     = l_res_q;
                    r_out_d     = flt_done ? flt_dout : r_lat_q;
                    timeout_set = ~flt_done;
                    out_valid_d = 1'b1;
                    state_d     = StIdle;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = StIdle;
        endcase

        if (smp_ready && (state_q != StIdle)) begin
            overrun_set = 1'b1;
        end

        overrun_d     = overrun_set | (overrun_q & ~clr_flags);
        timeout_err_d = timeout_set | (timeout_err_q & ~clr_flags);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q       <= StIdle;
            l_lat_q       <= '0;
            r_lat_q       <= '0;
            l_res_q       <= '0;
            flt_din_q     <= '0;
            flt_chan_q    <= 1'b0;
            l_out_q       <= '0;
            r_out_q       <= '0;
            out_valid_q   <= 1'b0;
            overrun_q     <= 1'b0;
            timeout_err_q <= 1'b0;
            cnt_q         <= '0;
        end else begin
            state_q       <= state_d;
            l_lat_q       <= l_lat_d;
            r_lat_q       <= r_lat_d;
            l_res_q       <= l_res_d;
            flt_din_q     <= flt_din_d;
            flt_chan_q    <= flt_chan_d;
            l_out_q       <= l_out_d;
            r_out_q       <= r_out_d;
            out_valid_q   <= out_valid_d;
            overrun_q     <= overrun_d;
            timeout_err_q <= timeout_err_d;
            cnt_q         <= cnt_d;
        end
    end

    assign flt_start   = (state_q == StStartL) || (state_q == StStartR);
    assign busy        = (state_q != StIdle);
    assign flt_din     = flt_din_q;
    assign flt_chan    = flt_chan_q;
    assign l_out       = l_out_q;
    assign r_out       = r_out_q;
    assign out_valid   = out_valid_q;
    assign overrun     = overrun_q;
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_filter_channel_scheduler.sv
// Scoreboard bench for filter_channel_scheduler: a behavioural filter with programmable
// per-channel latency, a frame-level reference model and an out_valid monitor.
module tb_filter_channel_scheduler;

    localparam int W  = 24;
    localparam int TO = 8;

    logic         clk = 1'b0;
    logic         reset_n, smp_ready, bypass, clr_flags, flt_done;
    logic [W-1:0] l_in, r_in, flt_dout;
    logic         flt_start, flt_chan, out_valid, busy, overrun, timeout_err;
    logic [W-1:0] flt_din, l_out, r_out;

    filter_channel_scheduler #(.W(W), .TIMEOUT(TO)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .smp_ready   (smp_ready),
        .l_in        (l_in),
        .r_in        (r_in),
        .bypass      (bypass),
        .clr_flags   (clr_flags),
        .flt_start   (flt_start),
        .flt_din     (flt_din),
        .flt_chan    (flt_chan),
        .flt_done    (flt_done),
        .flt_dout    (flt_dout),
        .l_out       (l_out),
        .r_out       (r_out),
        .out_valid   (out_valid),
        .busy        (busy),
        .overrun     (overrun),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    typedef struct {logic [W-1:0] l; logic [W-1:0] r;} exp_t;
    typedef struct {logic chan; logic [W-1:0] din;} start_t;

    exp_t   exp_q[$];
    start_t start_log[$];
    int     tests = 0, fails = 0;
    int     cyc = 0, ov_cyc = 0, ov_count = 0, send_cyc = 0;
    int     delay_l = 0, delay_r = 0;   // WAIT cycles before flt_done; -1 means never

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: a channel gets din+1 when the filter answers within TIMEOUT wait cycles,
    // otherwise its own input passes through.
    function automatic logic [W-1:0] chan_res(input logic [W-1:0] x, input int d);
        return (d >= 0 && d <= TO - 1) ? x + W'(1) : x;
    endfunction

    function automatic logic frame_timeout(input logic byp, input int dl, input int dr);
        return !byp && (dl < 0 || dl > TO - 1 || dr < 0 || dr > TO - 1);
    endfunction

    // Behavioural filter engine.
    initial begin : filter_model
        int cnt;
        logic active;
        logic [W-1:0] res;
        active = 1'b0;
        cnt = 0;
        res = '0;
        flt_done = 1'b0;
        flt_dout = '0;
        forever begin
            @(negedge clk);
            flt_done = 1'b0;
            if (!reset_n) begin
                active = 1'b0;
            end else begin
                if (active) begin
                    if (cnt == 0) begin
                        flt_done = 1'b1;
                        flt_dout = res;
                        active = 1'b0;
                    end else begin
                        cnt--;
                    end
                end
                if (flt_start) begin
                    res = flt_din + W'(1);
                    cnt = flt_chan ? delay_r : delay_l;
                    active = (cnt >= 0);
                end
            end
        end
    end

    always @(negedge clk) begin : monitor
        exp_t e;
        if (flt_start) start_log.push_back('{flt_chan, flt_din});
        if (out_valid) begin
            ov_cyc = cyc;
            ov_count++;
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_out_valid: l_out=%0h r_out=%0h, expected no pulse",
                         l_out, r_out);
            end else begin
                e = exp_q.pop_front();
                check("l_out", l_out, e.l);
                check("r_out", r_out, e.r);
            end
        end
    end

    initial begin : watchdog
        repeat (50000) @(posedge clk);
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic send(input logic [W-1:0] l, input logic [W-1:0] r, input logic byp);
        exp_t e;
        @(negedge clk);
        smp_ready = 1'b1;
        l_in = l;
        r_in = r;
        bypass = byp;
        start_log.delete();
        send_cyc = cyc;
        if (byp) e = '{l, r};
        else e = '{chan_res(l, delay_l), chan_res(r, delay_r)};
        exp_q.push_back(e);
        @(negedge clk);
        smp_ready = 1'b0;
        l_in = W'($urandom);
        r_in = W'($urandom);
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (n >= 200) begin
            tests++;
            fails++;
            $display("FAIL %s_timeout: %0d results still pending, expected 0", name,
                     exp_q.size());
            exp_q.delete();
        end
        check({name, "_busy"}, W'(busy), W'(0));
    endtask

    task automatic check_starts(input logic byp, input logic [W-1:0] l, input logic [W-1:0] r);
        check("n_starts", W'(start_log.size()), byp ? W'(0) : W'(2));
        if (!byp && start_log.size() == 2) begin
            check("start0_chan", W'(start_log[0].chan), W'(0));
            check("start0_din", start_log[0].din, l);
            check("start1_chan", W'(start_log[1].chan), W'(1));
            check("start1_din", start_log[1].din, r);
        end
    endtask

    task automatic clear_flags();
        @(negedge clk);
        clr_flags = 1'b1;
        @(negedge clk);
        clr_flags = 1'b0;
        check("clr_overrun", W'(overrun), W'(0));
        check("clr_timeout_err", W'(timeout_err), W'(0));
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_l_out"}, l_out, '0);
        check({name, "_r_out"}, r_out, '0);
        check({name, "_flt_din"}, flt_din, '0);
        check({name, "_flags"}, W'({flt_start, flt_chan, out_valid, busy, overrun,
                                    timeout_err}), W'(0));
    endtask

    initial begin : stimulus
        logic [W-1:0] l, r;
        logic byp;
        int ov_before, k;
        reset_n = 1'b0;
        smp_ready = 1'b0;
        bypass = 1'b0;
        clr_flags = 1'b0;
        l_in = '0;
        r_in = '0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        reset_n = 1'b1;

        // Filtered frame, filter answers after 3 wait cycles.
        delay_l = 3; delay_r = 3;
        send(24'h000123, 24'h000456, 1'b0);
        wait_idle("basic");
        check_starts(1'b0, 24'h000123, 24'h000456);
        check("basic_latency", W'(ov_cyc - send_cyc), W'(11));
        check("basic_l_out", l_out, 24'h000124);
        check("basic_terr", W'(timeout_err), W'(0));

        // Zero-wait filter: four edges from sampling edge to out_valid.
        delay_l = 0; delay_r = 0;
        send(24'h0A0B0C, 24'h0D0E0F, 1'b0);
        wait_idle("zero_wait");
        check("zero_wait_latency", W'(ov_cyc - send_cyc), W'(5));

        // Bypass.
        send(24'hABCDEF, 24'h123456, 1'b1);
        wait_idle("bypass");
        check_starts(1'b1, '0, '0);
        check("bypass_latency", W'(ov_cyc - send_cyc), W'(1));

        // Left channel never answers: passthrough after TO wait cycles.
        delay_l = -1; delay_r = 0;
        send(24'h111111, 24'h222222, 1'b0);
        wait_idle("timeout");
        check_starts(1'b0, 24'h111111, 24'h222222);
        check("timeout_latency", W'(ov_cyc - send_cyc), W'(5 + TO - 1));
        check("timeout_terr", W'(timeout_err), W'(1));
        clear_flags();

        // flt_done on the expiry cycle wins.
        delay_l = TO - 1; delay_r = TO - 1;
        send(24'h333333, 24'h444444, 1'b0);
        wait_idle("boundary");
        check("boundary_terr", W'(timeout_err), W'(0));

        // Second frame during WAIT_L is dropped; mid-frame bypass change is ignored.
        delay_l = 3; delay_r = 3;
        ov_before = ov_count;
        send(24'h555555, 24'h666666, 1'b0);
        @(negedge clk);
        smp_ready = 1'b1; bypass = 1'b1; l_in = 24'h777777; r_in = 24'h888888;
        @(negedge clk);
        smp_ready = 1'b0; bypass = 1'b0;
        wait_idle("overrun");
        repeat (5) @(negedge clk);
        check("overrun_pulses", W'(ov_count - ov_before), W'(1));
        check("overrun_flag", W'(overrun), W'(1));
        clear_flags();

        // Overrun coincident with clr_flags: set wins.
        send(24'h010101, 24'h020202, 1'b0);
        @(negedge clk);
        smp_ready = 1'b1; clr_flags = 1'b1;
        @(negedge clk);
        smp_ready = 1'b0; clr_flags = 1'b0;
        check("set_wins_overrun", W'(overrun), W'(1));
        wait_idle("set_wins");
        clear_flags();

        // Reset while in WAIT_R aborts the frame.
        delay_l = 0; delay_r = -1;
        send(24'h0F0F0F, 24'hF0F0F0, 1'b0);
        repeat (3) @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        check_all_zero("midreset");
        exp_q.delete();
        ov_before = ov_count;
        reset_n = 1'b1;
        repeat (20) @(negedge clk);
        check("midreset_no_pulse", W'(ov_count - ov_before), W'(0));
        delay_l = 2; delay_r = 2;
        send(24'h13579B, 24'h2468AC, 1'b0);
        wait_idle("post_reset");
        check_starts(1'b0, 24'h13579B, 24'h2468AC);

        // Randomized frames.
        for (int i = 0; i < 25; i++) begin
            l = W'($urandom);
            r = W'($urandom);
            byp = ($urandom_range(0, 3) == 0);
            k = $urandom_range(0, 9);
            delay_l = (k > TO - 1) ? -1 : k;
            k = $urandom_range(0, 9);
            delay_r = (k > TO - 1) ? -1 : k;
            send(l, r, byp);
            bypass = $urandom_range(0, 1);
            wait_idle("rand");
            check_starts(byp, l, r);
            check("rand_terr", W'(timeout_err), W'(frame_timeout(byp, delay_l, delay_r)));
            check("rand_overrun", W'(overrun), W'(0));
            if (timeout_err) clear_flags();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
